// File: rtl/wb_write_arbiter_if.sv
// Bus bundle for wb_write_arbiter: pipeline write-back request, multi-cycle
// result handshake, register-file write port and status outputs.
// The slave modport is the arbiter's view and the master modport is the
// environment's view.
interface wb_write_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                  i_Sig_Write_Back_Enable;
  logic [3:0]            i_Destination;
  logic [DATA_WIDTH-1:0] i_Write_Back_Value;
  logic                  i_Mc_Valid;
  logic [3:0]            i_Mc_Destination;
  logic [DATA_WIDTH-1:0] i_Mc_Value;
  logic                  o_Mc_Ready;
  logic                  o_Rf_Write_Enable;
  logic [3:0]            o_Rf_Destination;
  logic [DATA_WIDTH-1:0] o_Rf_Value;
  logic                  o_Stall_Pipeline;
  logic [CW-1:0]         o_Queue_Count;

  modport slave (
    input  i_Sig_Write_Back_Enable, i_Destination, i_Write_Back_Value,
    input  i_Mc_Valid, i_Mc_Destination, i_Mc_Value,
    output o_Mc_Ready, o_Rf_Write_Enable, o_Rf_Destination, o_Rf_Value,
    output o_Stall_Pipeline, o_Queue_Count
  );

  modport master (
    output i_Sig_Write_Back_Enable, i_Destination, i_Write_Back_Value,
    output i_Mc_Valid, i_Mc_Destination, i_Mc_Value,
    input  o_Mc_Ready, o_Rf_Write_Enable, o_Rf_Destination, o_Rf_Value,
    input  o_Stall_Pipeline, o_Queue_Count
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter. The pipeline write-back always wins;
// multi-cycle results wait in an in-order queue and drain into idle cycles.
// A pipeline write kills older queued results to the same register, and a
// starvation counter raises a bubble request when the head keeps losing.
// Optional macro WB_ARB_STATS_EN adds saturating conflict/kill counters.
module wb_write_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  wb_write_arbiter_if.slave bus
`ifdef WB_ARB_STATS_EN
  ,
  output logic [15:0] o_Conflict_Count,
  output logic [15:0] o_Kill_Count
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [FIFO_DEPTH-1:0] live_q, live_d, kill;
  logic [3:0]            dst_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] val_q [FIFO_DEPTH];
  logic [7:0]            starve_q, starve_d;
  logic                  stall_q, stall_d;
  logic                  rf_we_q, rf_we_d;
  logic [3:0]            rf_dst_q, rf_dst_d;
  logic [DATA_WIDTH-1:0] rf_val_q, rf_val_d;
  logic                  mc_ready, q_empty, head_live, push, pop, conflict, wb_en;

  assign wb_en     = bus.i_Sig_Write_Back_Enable;
  assign mc_ready  = (count_q < CW'(FIFO_DEPTH));
  assign q_empty   = (count_q == '0);
  assign head_live = !q_empty && live_q[rd_ptr_q];
  assign push      = bus.i_Mc_Valid && mc_ready;
  // A live head pops only when the pipeline is idle; a dead head pops always.
  assign pop       = !q_empty && (!wb_en || !live_q[rd_ptr_q]);
  assign conflict  = wb_en && head_live;

  // Next-state: queue bookkeeping, write-after-write kills, arbitration, starvation.
  always_comb begin
    live_d = live_q;
    kill   = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      kill[i] = wb_en && live_q[i] && (dst_q[i] == bus.i_Destination);
    end
    if (pop) live_d[rd_ptr_q] = 1'b0;
    live_d = live_d & ~kill;
    // The entry pushed this cycle is younger than the pipeline write.
    if (push) live_d[wr_ptr_q] = 1'b1;

    rd_ptr_d = rd_ptr_q + AW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);

    rf_we_d  = 1'b0;
    rf_dst_d = rf_dst_q;
    rf_val_d = rf_val_q;
    if (wb_en) begin
      rf_we_d  = 1'b1;
      rf_dst_d = bus.i_Destination;
      rf_val_d = bus.i_Write_Back_Value;
    end else if (head_live) begin
      rf_we_d  = 1'b1;
      rf_dst_d = dst_q[rd_ptr_q];
      rf_val_d = val_q[rd_ptr_q];
    end

    starve_d = starve_q;
    stall_d  = stall_q;
    if (q_empty || pop) begin
      starve_d = '0;
      stall_d  = 1'b0;
    end else begin
      if (conflict && starve_q != 8'hFF) starve_d = starve_q + 8'd1;
      if (starve_q == 8'(STARVE_LIMIT)) stall_d = 1'b1;
    end
  end

  // Control and output registers; reset discards all queued results.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      live_q   <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      rf_we_q  <= 1'b0;
      rf_dst_q <= '0;
      rf_val_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      live_q   <= live_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      rf_we_q  <= rf_we_d;
      rf_dst_q <= rf_dst_d;
      rf_val_q <= rf_val_d;
    end
  end

  // Queue payload storage; validity is tracked separately by live_q.
  always_ff @(posedge clk) begin
    if (push) begin
      dst_q[wr_ptr_q] <= bus.i_Mc_Destination;
      val_q[wr_ptr_q] <= bus.i_Mc_Value;
    end
  end

  assign bus.o_Mc_Ready        = mc_ready;
  assign bus.o_Rf_Write_Enable = rf_we_q;
  assign bus.o_Rf_Destination  = rf_dst_q;
  assign bus.o_Rf_Value        = rf_val_q;
  assign bus.o_Stall_Pipeline  = stall_q;
  assign bus.o_Queue_Count     = count_q;

`ifdef WB_ARB_STATS_EN
  logic [15:0] conf_cnt_q, kill_cnt_q;
  logic [16:0] kill_sum;

  always_comb begin
    kill_sum = {1'b0, kill_cnt_q};
    for (int i = 0; i < FIFO_DEPTH; i++) kill_sum = kill_sum + 17'(kill[i]);
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      conf_cnt_q <= '0;
      kill_cnt_q <= '0;
    end else begin
      if (conflict && conf_cnt_q != 16'hFFFF) conf_cnt_q <= conf_cnt_q + 16'd1;
      kill_cnt_q <= kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
    end
  end

  assign o_Conflict_Count = conf_cnt_q;
  assign o_Kill_Count     = kill_cnt_q;
`endif
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: stimulus pushes each expected
// register-file write (with the cycle it must appear in) into a queue; a
// negedge monitor compares every strobe against the queue head.
module tb_wb_write_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wb_write_arbiter_if #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) bus ();

`ifdef WB_ARB_STATS_EN
  logic [15:0] conf_cnt, kill_cnt;
`endif

  wb_write_arbiter #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef WB_ARB_STATS_EN
    ,
    .o_Conflict_Count (conf_cnt),
    .o_Kill_Count     (kill_cnt)
`endif
  );

  typedef struct {
    logic [3:0]  d;
    logic [31:0] v;
    int          cyc;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_bad = 0;
  int  cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the oldest expectation and its cycle.
  always @(negedge clk) begin
    wr_t e;
    if (bus.o_Rf_Write_Enable === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got dest=%0d val=%h, required no strobe",
                 bus.o_Rf_Destination, bus.o_Rf_Value);
      end else begin
        e = exp_q.pop_front();
        if (bus.o_Rf_Destination !== e.d || bus.o_Rf_Value !== e.v || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL rf_write: got dest=%0d val=%h cyc=%0d, required dest=%0d val=%h cyc=%0d",
                   bus.o_Rf_Destination, bus.o_Rf_Value, cyc, e.d, e.v, e.cyc);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      n_vec++;
      n_bad++;
      e = exp_q.pop_front();
      $display("FAIL missing_write: got no strobe at cyc=%0d, required dest=%0d val=%h",
               cyc, e.d, e.v);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic wb, input logic [3:0] d, input logic [31:0] v,
                     input logic mv, input logic [3:0] md, input logic [31:0] mvv);
    bus.i_Sig_Write_Back_Enable = wb;
    bus.i_Destination           = d;
    bus.i_Write_Back_Value      = v;
    bus.i_Mc_Valid              = mv;
    bus.i_Mc_Destination        = md;
    bus.i_Mc_Value              = mvv;
  endtask

  // Expect a strobe right after the coming edge.
  task automatic expect_wr(input logic [3:0] d, input logic [31:0] v);
    wr_t e;
    e.d = d;
    e.v = v;
    e.cyc = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  initial begin
    drv(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state.
    chk("rst_we",    32'(bus.o_Rf_Write_Enable), 32'd0);
    chk("rst_dst",   32'(bus.o_Rf_Destination),  32'd0);
    chk("rst_val",   bus.o_Rf_Value,             32'd0);
    chk("rst_stall", 32'(bus.o_Stall_Pipeline),  32'd0);
    chk("rst_ready", 32'(bus.o_Mc_Ready),        32'd1);
    chk("rst_count", 32'(bus.o_Queue_Count),     32'd0);

    // Single pipeline write with empty queue.
    drv(1'b1, 4'd1, 32'hABCD1234, 1'b0, 4'd0, 32'd0);
    expect_wr(4'd1, 32'hABCD1234);
    tick();
    drv(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    tick();

    // Queued R2 waits behind three pipeline writes to R3.
    drv(1'b1, 4'd3, 32'h11223344, 1'b1, 4'd2, 32'h55667788);
    expect_wr(4'd3, 32'h11223344);
    tick();
    chk("t3_count0", 32'(bus.o_Queue_Count), 32'd1);
    bus.i_Mc_Valid = 1'b0;
    for (int k = 1; k < 3; k++) begin
      expect_wr(4'd3, 32'h11223344);
      tick();
      chk("t3_count", 32'(bus.o_Queue_Count), 32'd1);
    end
    drv(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    expect_wr(4'd2, 32'h55667788);
    tick();
    chk("t3_count3", 32'(bus.o_Queue_Count), 32'd0);

    // WAW kill: queued R4 superseded by a pipeline write to R4.
    drv(1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 32'hAAAA0000);
    tick();
    drv(1'b1, 4'd4, 32'hBBBB0000, 1'b0, 4'd0, 32'd0);
    expect_wr(4'd4, 32'hBBBB0000);
    tick();
    chk("kill_count_dead", 32'(bus.o_Queue_Count), 32'd1);
    drv(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    tick();
    chk("kill_popped", 32'(bus.o_Queue_Count), 32'd0);
    tick();
`ifdef WB_ARB_STATS_EN
    chk("stat_kill", 32'(kill_cnt), 32'd1);
`endif

    // Fill under continuous pipeline writes, starve, stall, then drain.
    for (int k = 0; k < 4; k++) begin
      drv(1'b1, 4'd9, 32'h90000000 + k, 1'b1, 4'(5 + k), 32'h50000000 + k);
      expect_wr(4'd9, 32'h90000000 + k);
      tick();
    end
    chk("full_ready", 32'(bus.o_Mc_Ready),    32'd0);
    chk("full_count", 32'(bus.o_Queue_Count), 32'd4);
    for (int j = 4; j <= 10; j++) begin
      // Push attempt at j=4 is made while full and must be refused.
      drv(1'b1, 4'd9, 32'h90000000 + j, (j == 4), 4'd15, 32'hFFFF0000);
      expect_wr(4'd9, 32'h90000000 + j);
      tick();
      if (j == 8)  chk("stall_pre",  32'(bus.o_Stall_Pipeline), 32'd0);
      if (j == 9)  chk("stall_rise", 32'(bus.o_Stall_Pipeline), 32'd1);
      if (j == 10) chk("stall_hold", 32'(bus.o_Stall_Pipeline), 32'd1);
    end
    // Pipeline idles; a push offered while still full is refused despite the pop.
    drv(1'b0, 4'd0, 32'd0, 1'b1, 4'd15, 32'hFFFF0001);
    expect_wr(4'd5, 32'h50000000);
    tick();
    chk("stall_fall",  32'(bus.o_Stall_Pipeline), 32'd0);
    chk("drain_count", 32'(bus.o_Queue_Count),    32'd3);
    chk("drain_ready", 32'(bus.o_Mc_Ready),       32'd1);
    bus.i_Mc_Valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      expect_wr(4'(5 + k), 32'h50000000 + k);
      tick();
    end
    chk("drain_empty", 32'(bus.o_Queue_Count), 32'd0);
`ifdef WB_ARB_STATS_EN
    chk("stat_conflict", 32'(conf_cnt), 32'd13);
`endif

    // Reset with three entries queued discards them.
    for (int k = 0; k < 3; k++) begin
      drv(1'b1, 4'd13, 32'hD0 + k, 1'b1, 4'(10 + k), 32'hC0 + k);
      expect_wr(4'd13, 32'hD0 + k);
      tick();
    end
    chk("pre_rst_count", 32'(bus.o_Queue_Count), 32'd3);
    drv(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    reset = 1'b1;
    tick();
    chk("mid_rst_count", 32'(bus.o_Queue_Count),    32'd0);
    chk("mid_rst_stall", 32'(bus.o_Stall_Pipeline), 32'd0);
    chk("mid_rst_we",    32'(bus.o_Rf_Write_Enable), 32'd0);
    reset = 1'b0;
    repeat (5) tick();
    chk("post_rst_count", 32'(bus.o_Queue_Count), 32'd0);
`ifdef WB_ARB_STATS_EN
    chk("stat_rst_conf", 32'(conf_cnt), 32'd0);
    chk("stat_rst_kill", 32'(kill_cnt), 32'd0);
`endif
    chk("exp_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Shares the single register-file write port between two requesters:
  - the pipeline write-back stage, which is never back-pressured and always has priority;
  - a multi-cycle execution unit (multiply/divide), which returns results out of pipeline order through a valid/ready handshake.
- Multi-cycle results are held in a small in-order queue and drained into idle write-port cycles.
- Enforces write-after-write ordering and prevents starvation by requesting pipeline bubbles.

Parameters:
- DATA_WIDTH, 32, register value width.
- FIFO_DEPTH, 4, multi-cycle result queue entries; power of 2, minimum 2.
- STARVE_LIMIT, 8, consecutive lost-arbitration cycles before a bubble is requested; range 1..255.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- i_Sig_Write_Back_Enable  input  1  pipeline write-back request this cycle
- i_Destination  input  4  pipeline destination register
- i_Write_Back_Value  input  DATA_WIDTH  pipeline write data
- i_Mc_Valid  input  1  multi-cycle result valid
- i_Mc_Destination  input  4  multi-cycle destination register
- i_Mc_Value  input  DATA_WIDTH  multi-cycle result data
- o_Mc_Ready  output  1  queue can accept a result
- o_Rf_Write_Enable  output  1  register-file write strobe
- o_Rf_Destination  output  4  register-file write address
- o_Rf_Value  output  DATA_WIDTH  register-file write data
- o_Stall_Pipeline  output  1  request one or more bubbles at write-back
- o_Queue_Count  output  log2(FIFO_DEPTH)+1  occupied queue entries, including killed entries

Behaviour:
- Single clock domain; everything is sampled on the rising edge of clk.
- Reset:
  - clears the queue (count 0, both pointers 0, all entry valid bits 0) and the starvation counter;
  - o_Rf_Write_Enable, o_Rf_Destination, o_Rf_Value and o_Stall_Pipeline are 0.
  - Reset asserted mid-drain discards all queued results with no write.
- Outputs o_Rf_* and o_Stall_Pipeline are registered, giving 1-cycle latency from the winning request to the register-file strobe.
- Handshake:
  - o_Mc_Ready = (count < FIFO_DEPTH), derived from the registered count.
  - A push occurs when i_Mc_Valid and o_Mc_Ready are both high.
  - When full, a push is refused even if a pop happens in the same cycle.
- Each queue entry holds a destination, a value and a live bit; pushed entries are live.
- Arbitration, evaluated each cycle:
  - If i_Sig_Write_Back_Enable = 1: the pipeline wins and the next o_Rf_* carry its destination and value.
  - Otherwise, if the head entry is live: the head wins, is popped and is written.
  - A dead head entry is popped without a write in any cycle, including cycles where the pipeline wins. At most one pop per cycle.
- WAW kill:
  - When the pipeline writes register R, every queued live entry with destination R is marked dead in that cycle.
  - An entry pushed in the same cycle is not killed; it is treated as younger than the pipeline write.
- Simultaneous push and pop: count is unchanged and both pointers advance. Pointers wrap modulo FIFO_DEPTH.
- Starvation counter:
  - Increments in each cycle where the head is live and the pipeline wins.
  - Clears when the head is popped or the queue is empty.
  - When the counter equals STARVE_LIMIT, o_Stall_Pipeline is set on the next edge.
  - o_Stall_Pipeline stays set until the cycle after the starved entry is popped, then clears together with the counter.
  - A pipeline write arriving while o_Stall_Pipeline = 1 still wins. The stall is a request only, never an override.
- o_Rf_Write_Enable = 0 whenever there is no winner; o_Rf_Destination and o_Rf_Value hold their last values.

Optional Feature:
- Macro: WB_ARB_STATS_EN.
- Defined:
  - adds output o_Conflict_Count [15:0], a saturating count of cycles where the pipeline wins while the head is live;
  - adds output o_Kill_Count [15:0], a saturating count of entries marked dead;
  - both counters reset to 0.
- Undefined: neither port nor its logic exists. All other behaviour is identical.

Test Plan:
- Reset release with no traffic -> all outputs 0, o_Mc_Ready = 1, o_Queue_Count = 0.
- Pipeline write R1=0xABCD1234 with the queue empty -> next cycle o_Rf_Write_Enable = 1, o_Rf_Destination = 1, o_Rf_Value = 0xABCD1234.
- Push R2=0x55667788 while the pipeline writes R3=0x11223344 for 3 cycles, then goes idle:
  - R3 is written each pipeline cycle;
  - R2=0x55667788 is written in the cycle after the first idle cycle;
  - o_Queue_Count sequence is 1,1,1,0.
- Queue R4=0xAAAA0000, then the pipeline writes R4=0xBBBB0000 -> only 0xBBBB0000 reaches R4; the dead entry pops without a strobe (o_Kill_Count = 1 when WB_ARB_STATS_EN is defined).
- Fill the queue with 4 pushes under continuous pipeline writes:
  - o_Mc_Ready = 0 after the 4th push;
  - o_Stall_Pipeline rises after 8 lost cycles;
  - after the pipeline idles, the head drains, o_Stall_Pipeline falls and o_Mc_Ready returns to 1.
- Assert reset while 3 entries are queued -> no further writes, o_Queue_Count = 0, o_Stall_Pipeline = 0 on the next edge.
